// File: rtl/ysyx_23060191_csr_ctrl.sv
// Sequencer between decode and the CSR register file: runs one SYSTEM instruction
// at a time (CSRRW/S/C, ECALL, MRET), drives CSR strobes, returns rd data and PC redirects.
`timescale 1ns/1ps
module ysyx_23060191_csr_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_imm,
    input  logic             in_src_zero,
    input  logic [WIDTH-1:0] in_rs1,
    input  logic [4:0]       in_zimm,
    input  logic [11:0]      in_csr_addr,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_a5,
    output logic [11:0]      addr_rd_csr,
    input  logic [WIDTH-1:0] data_rd_csr,
    output logic             wr_en_csr,
    output logic [11:0]      addr_wr_csr,
    output logic [WIDTH-1:0] data_wr_csr,
    output logic             ecall_en,
    output logic [WIDTH-1:0] ecall_NO,
    input  logic [WIDTH-1:0] mtvec,
    input  logic [WIDTH-1:0] mepc,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [WIDTH-1:0] redir_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             rd_we,
    output logic [WIDTH-1:0] rd_wdata,
    output logic             illegal
);

    localparam logic [2:0] OP_CSRRW = 3'b001;
    localparam logic [2:0] OP_CSRRS = 3'b010;
    localparam logic [2:0] OP_CSRRC = 3'b011;
    localparam logic [2:0] OP_ECALL = 3'b100;
    localparam logic [2:0] OP_MRET  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_REDIR,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_src;
    logic [WIDTH-1:0] r_pc;

    logic             w_in_csr;
    logic             w_in_setclr;
    logic [WIDTH-1:0] w_in_src;
    logic [WIDTH-1:0] w_data_wr;

    assign w_in_setclr = (in_op == OP_CSRRS) || (in_op == OP_CSRRC);
    assign w_in_csr    = (in_op == OP_CSRRW) || w_in_setclr;
    assign w_in_src    = in_imm ? WIDTH'(in_zimm) : in_rs1;

    // Write data depends on the CSR value read during EXEC, so it is formed combinationally
    always_comb begin
        w_data_wr = '0;
        if (r_state == S_EXEC) begin
            case (r_op)
                OP_CSRRW: w_data_wr = r_src;
                OP_CSRRS: w_data_wr = data_rd_csr | r_src;
                OP_CSRRC: w_data_wr = data_rd_csr & ~r_src;
                OP_ECALL: w_data_wr = r_pc;
                default:  w_data_wr = '0;
            endcase
        end
    end

    assign data_wr_csr = w_data_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_src       <= '0;
            r_pc        <= '0;
            in_ready    <= 1'b0;
            addr_rd_csr <= '0;
            wr_en_csr   <= 1'b0;
            addr_wr_csr <= '0;
            ecall_en    <= 1'b0;
            ecall_NO    <= '0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            out_valid   <= 1'b0;
            rd_we       <= 1'b0;
            rd_wdata    <= '0;
            illegal     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        // Strobes are decided at accept so they are registered for the EXEC cycle
                        r_state     <= S_EXEC;
                        in_ready    <= 1'b0;
                        r_op        <= in_op;
                        r_src       <= w_in_src;
                        r_pc        <= in_pc;
                        addr_rd_csr <= in_csr_addr;
                        addr_wr_csr <= w_in_csr ? in_csr_addr : 12'h000;
                        wr_en_csr   <= (in_op == OP_CSRRW) || (w_in_setclr && !in_src_zero);
                        ecall_en    <= (in_op == OP_ECALL);
                        ecall_NO    <= (in_op == OP_ECALL) ? in_a5 : '0;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_EXEC: begin
                    wr_en_csr <= 1'b0;
                    ecall_en  <= 1'b0;
                    case (r_op)
                        OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
                            rd_we     <= 1'b1;
                            rd_wdata  <= data_rd_csr;
                            illegal   <= 1'b0;
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end
                        OP_ECALL, OP_MRET: begin
                            rd_we       <= 1'b0;
                            rd_wdata    <= '0;
                            illegal     <= 1'b0;
                            redir_pc    <= (r_op == OP_ECALL) ? mtvec : mepc;
                            redir_valid <= 1'b1;
                            r_state     <= S_REDIR;
                        end
                        default: begin
                            rd_we     <= 1'b0;
                            rd_wdata  <= '0;
                            illegal   <= 1'b1;
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    endcase
                end
                S_REDIR: begin
                    if (redir_ready) begin
                        redir_valid <= 1'b0;
                        out_valid   <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060191_csr_ctrl.sv
// Bench for ysyx_23060191_csr_ctrl: CSR file stub plus an instruction-level reference model,
// directed scenarios followed by randomized instruction streams with random backpressure.
`timescale 1ns/1ps
module tb_ysyx_23060191_csr_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic             in_imm;
    logic             in_src_zero;
    logic [WIDTH-1:0] in_rs1;
    logic [4:0]       in_zimm;
    logic [11:0]      in_csr_addr;
    logic [WIDTH-1:0] in_pc;
    logic [WIDTH-1:0] in_a5;
    logic [11:0]      addr_rd_csr;
    logic [WIDTH-1:0] data_rd_csr;
    logic             wr_en_csr;
    logic [11:0]      addr_wr_csr;
    logic [WIDTH-1:0] data_wr_csr;
    logic             ecall_en;
    logic [WIDTH-1:0] ecall_NO;
    logic [WIDTH-1:0] mtvec;
    logic [WIDTH-1:0] mepc;
    logic             redir_valid;
    logic             redir_ready;
    logic [WIDTH-1:0] redir_pc;
    logic             out_valid;
    logic             out_ready;
    logic             rd_we;
    logic [WIDTH-1:0] rd_wdata;
    logic             illegal;

    logic [WIDTH-1:0] env_csr [4096];
    logic [WIDTH-1:0] ref_csr [4096];
    logic             pl_en;
    logic [11:0]      pl_addr;
    logic [WIDTH-1:0] pl_data;
    logic [11:0]      addr_tbl [5] = '{A_MSTATUS, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE};

    int n_checks = 0;
    int n_errors = 0;

    ysyx_23060191_csr_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_imm(in_imm),
        .in_src_zero(in_src_zero), .in_rs1(in_rs1), .in_zimm(in_zimm),
        .in_csr_addr(in_csr_addr), .in_pc(in_pc), .in_a5(in_a5),
        .addr_rd_csr(addr_rd_csr), .data_rd_csr(data_rd_csr),
        .wr_en_csr(wr_en_csr), .addr_wr_csr(addr_wr_csr), .data_wr_csr(data_wr_csr),
        .ecall_en(ecall_en), .ecall_NO(ecall_NO), .mtvec(mtvec), .mepc(mepc),
        .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd_we(rd_we), .rd_wdata(rd_wdata), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // CSR file stub driven only by the DUT strobes (and a bench preload port)
    assign data_rd_csr = env_csr[addr_rd_csr];
    assign mtvec       = env_csr[A_MTVEC];
    assign mepc        = env_csr[A_MEPC];

    always @(posedge clk) begin
        if (pl_en) env_csr[pl_addr] <= pl_data;
        if (wr_en_csr) env_csr[addr_wr_csr] <= data_wr_csr;
        if (ecall_en) begin
            env_csr[A_MEPC]   <= data_wr_csr;
            env_csr[A_MCAUSE] <= ecall_NO;
        end
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [WIDTH-1:0] v);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = v;
        tick();
        pl_en = 1'b0;
        ref_csr[a] = v;
    endtask

    task automatic wait_ready();
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic scramble_inputs();
        in_valid    = 1'($urandom);
        in_op       = 3'($urandom);
        in_imm      = 1'($urandom);
        in_src_zero = 1'($urandom);
        in_rs1      = $urandom;
        in_zimm     = 5'($urandom);
        in_csr_addr = 12'($urandom);
        in_pc       = $urandom;
        in_a5       = $urandom;
    endtask

    // Issue one instruction and check every observable step against the model
    task automatic do_instr(input logic [2:0] op, input logic imm, input logic sz,
                            input logic [WIDTH-1:0] rs1, input logic [4:0] zimm,
                            input logic [11:0] addr, input logic [WIDTH-1:0] pc,
                            input logic [WIDTH-1:0] a5, input int rdly, input int odly);
        logic [WIDTH-1:0] old_v, src, nv, exp_rpc;
        logic             we, is_csr, is_redir;
        old_v    = ref_csr[addr];
        src      = imm ? {27'd0, zimm} : rs1;
        is_csr   = (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
        is_redir = (op == 3'd4) || (op == 3'd5);
        nv = '0;
        we = 1'b0;
        if (op == 3'd1) begin
            nv = src; we = 1'b1;
        end else if (op == 3'd2) begin
            nv = old_v | src; we = !sz;
        end else if (op == 3'd3) begin
            nv = old_v & ~src; we = !sz;
        end
        exp_rpc = (op == 3'd4) ? ref_csr[A_MTVEC] : ref_csr[A_MEPC];

        wait_ready();
        in_valid = 1'b1; in_op = op; in_imm = imm; in_src_zero = sz; in_rs1 = rs1;
        in_zimm = zimm; in_csr_addr = addr; in_pc = pc; in_a5 = a5;
        tick();
        scramble_inputs();

        // EXEC cycle
        check("exec_in_ready", 32'(in_ready), 32'd0);
        check("exec_addr_rd", 32'(addr_rd_csr), 32'(addr));
        check("exec_wr_en", 32'(wr_en_csr), 32'(we));
        if (we) begin
            check("exec_addr_wr", 32'(addr_wr_csr), 32'(addr));
            check("exec_data_wr", data_wr_csr, nv);
        end
        check("exec_ecall_en", 32'(ecall_en), 32'(op == 3'd4));
        if (op == 3'd4) begin
            check("exec_ecall_pc", data_wr_csr, pc);
            check("exec_ecall_no", ecall_NO, a5);
        end
        check("exec_out_valid", 32'(out_valid), 32'd0);
        tick();
        check("post_exec_strobes", 32'({wr_en_csr, ecall_en}), 32'd0);

        if (is_redir) begin
            check("redir_valid", 32'(redir_valid), 32'd1);
            check("redir_pc", redir_pc, exp_rpc);
            check("redir_no_out", 32'(out_valid), 32'd0);
            for (int i = 0; i < rdly; i++) begin
                redir_ready = 1'b0;
                tick();
                check("redir_hold_valid", 32'(redir_valid), 32'd1);
                check("redir_hold_pc", redir_pc, exp_rpc);
                check("redir_hold_strobes", 32'({wr_en_csr, ecall_en, out_valid}), 32'd0);
            end
            redir_ready = 1'b1;
            tick();
            redir_ready = 1'b0;
            check("redir_dropped", 32'(redir_valid), 32'd0);
        end else begin
            check("no_redir", 32'(redir_valid), 32'd0);
        end

        check("out_valid", 32'(out_valid), 32'd1);
        check("out_rd_we", 32'(rd_we), 32'(is_csr));
        check("out_illegal", 32'(illegal), 32'(!(is_csr || is_redir)));
        if (is_csr) check("out_rd_wdata", rd_wdata, old_v);
        for (int i = 0; i < odly; i++) begin
            out_ready = 1'b0;
            tick();
            check("out_hold_valid", 32'(out_valid), 32'd1);
            check("out_hold_busy", 32'({in_ready, wr_en_csr, ecall_en}), 32'd0);
            check("out_hold_flags", 32'({rd_we, illegal}), 32'({is_csr, !(is_csr || is_redir)}));
            if (is_csr) check("out_hold_wdata", rd_wdata, old_v);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("done_out_valid", 32'(out_valid), 32'd0);
        check("done_in_ready", 32'(in_ready), 32'd1);

        if (we) ref_csr[addr] = nv;
        if (op == 3'd4) begin
            ref_csr[A_MEPC]   = pc;
            ref_csr[A_MCAUSE] = a5;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_imm = 1'b0; in_src_zero = 1'b0;
        in_rs1 = '0; in_zimm = '0; in_csr_addr = '0; in_pc = '0; in_a5 = '0;
        redir_ready = 1'b0; out_ready = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        tick();
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_outputs", 32'(|{addr_rd_csr, wr_en_csr, addr_wr_csr, data_wr_csr, ecall_en,
                                     ecall_NO, redir_valid, redir_pc, out_valid, rd_we, rd_wdata,
                                     illegal}), 32'd0);
        rst_n = 1'b1;
        tick();
        check("release_in_ready", 32'(in_ready), 32'd1);
        foreach (addr_tbl[i]) preload(addr_tbl[i], 32'd0);

        // CSRRW mtvec
        do_instr(3'd1, 1'b0, 1'b0, 32'h8000_0100, 5'd0, A_MTVEC, 32'h0, 32'h0, 0, 0);
        // CSRRS / CSRRC on mcause
        preload(A_MCAUSE, 32'h0000_00F0);
        do_instr(3'd2, 1'b1, 1'b0, 32'h0, 5'h0F, A_MCAUSE, 32'h0, 32'h0, 0, 1);
        check("csrrs_result", env_csr[A_MCAUSE], 32'h0000_00FF);
        do_instr(3'd3, 1'b0, 1'b0, 32'h0000_00F0, 5'd0, A_MCAUSE, 32'h0, 32'h0, 0, 0);
        check("csrrc_result", env_csr[A_MCAUSE], 32'h0000_000F);
        do_instr(3'd2, 1'b0, 1'b1, 32'h0, 5'd0, A_MCAUSE, 32'h0, 32'h0, 0, 0);
        check("csrrs_zero_keeps", env_csr[A_MCAUSE], 32'h0000_000F);
        // ECALL after mtvec write, redirect backpressure
        do_instr(3'd4, 1'b0, 1'b0, 32'h0, 5'd0, 12'h000, 32'h8000_0040, 32'd11, 3, 0);
        check("ecall_mepc", env_csr[A_MEPC], 32'h8000_0040);
        check("ecall_mcause", env_csr[A_MCAUSE], 32'd11);
        // MRET
        preload(A_MEPC, 32'h8000_0044);
        do_instr(3'd5, 1'b0, 1'b0, 32'h0, 5'd0, 12'h000, 32'h0, 32'h0, 1, 0);
        // Illegal op with src_zero, long writeback backpressure
        do_instr(3'd7, 1'b1, 1'b1, 32'h0, 5'd0, A_MSTATUS, 32'h0, 32'h0, 0, 5);
        // mstatus behaves like any other CSR
        do_instr(3'd1, 1'b0, 1'b0, 32'h0000_1888, 5'd0, A_MSTATUS, 32'h0, 32'h0, 0, 0);
        check("mstatus_plain", env_csr[A_MSTATUS], 32'h0000_1888);

        // Reset while a redirect is pending
        wait_ready();
        in_valid = 1'b1; in_op = 3'd4; in_pc = 32'h8000_0200; in_a5 = 32'd8; in_csr_addr = 12'h000;
        tick();
        in_valid = 1'b0;
        tick();
        check("rst_pre_redir", 32'(redir_valid), 32'd1);
        ref_csr[A_MEPC]   = 32'h8000_0200;
        ref_csr[A_MCAUSE] = 32'd8;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_redir", 32'(redir_valid), 32'd0);
        check("rst_async_ready", 32'(in_ready), 32'd0);
        #3 rst_n = 1'b1;
        tick();
        check("rst_release_ready", 32'(in_ready), 32'd1);
        check("rst_release_outputs", 32'(|{addr_rd_csr, wr_en_csr, addr_wr_csr, data_wr_csr,
                                           ecall_en, ecall_NO, redir_valid, redir_pc, out_valid,
                                           rd_we, rd_wdata, illegal}), 32'd0);
        check("rst_ecall_landed", env_csr[A_MEPC], 32'h8000_0200);

        // Random instruction stream
        for (int k = 0; k < 60; k++) begin
            logic [2:0]       op;
            logic             imm, sz;
            logic [WIDTH-1:0] rs1;
            logic [4:0]       zimm;
            int               sel;
            sel = int'($urandom_range(0, 9));
            if (sel <= 2)      op = 3'd1;
            else if (sel <= 4) op = 3'd2;
            else if (sel <= 6) op = 3'd3;
            else if (sel == 7) op = 3'd4;
            else if (sel == 8) op = 3'd5;
            else begin
                sel = int'($urandom_range(0, 2));
                op  = (sel == 0) ? 3'd0 : ((sel == 1) ? 3'd6 : 3'd7);
            end
            imm  = 1'($urandom);
            sz   = ($urandom_range(0, 3) == 0);
            rs1  = sz ? 32'h0 : $urandom;
            zimm = sz ? 5'd0 : 5'($urandom_range(1, 31));
            if ($urandom_range(0, 9) == 0)
                preload(addr_tbl[$urandom_range(0, 4)], $urandom);
            do_instr(op, imm, sz, rs1, zimm, addr_tbl[$urandom_range(0, 4)], $urandom, $urandom,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
